// File: rtl/decode_pkg.sv
// Shared state encoding and constants for the 4x4 block decode burst sequencer.
package decode_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_BURST = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

    localparam int         BLK_LEN   = 16;
    localparam int         BEAT_W    = 4;
    localparam logic [4:0] BLK_LEVEL = 5'd16;

    // A zero-length frame is promoted to a single block.
    function automatic logic [15:0] norm_blks(input logic [15:0] n);
        logic [15:0] r;
        if (n == 16'd0) begin
            r = 16'd1;
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage

// File: rtl/decode_seq_tpg.sv
// Ramp test-pattern source: emits beat+1 one cycle after the beat, matching FIFO read latency.
module decode_seq_tpg
    import decode_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BEAT_W-1:0] beat,
    output logic [7:0]        ramp
);

    // Register the ramp value so it lines up with src_data timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp <= 8'd0;
        end else begin
            ramp <= 8'(beat) + 8'd1;
        end
    end

endmodule

// File: rtl/decode_burst_seq.sv
// Burst sequencer feeding decode_4x4 with gap-separated 16-beat bursts, one per block.
// Optional ramp test source is built only when DECODE_SEQ_TESTPAT_EN is defined.
module decode_burst_seq
    import decode_pkg::*;
#(
    parameter int START_DLY = 400,
    parameter int GAP       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] frame_blks,
    input  logic        test_mode,
    input  logic [4:0]  src_level,
    input  logic [7:0]  src_data,
    output logic        src_rd,
    output logic [7:0]  dec_data,
    output logic        dec_de,
    output logic        busy,
    output logic [15:0] blk_cnt,
    output logic        frame_done
);

    localparam logic [15:0]       INIT_LAST = 16'(START_DLY - 1);
    localparam logic [3:0]        GAP_LAST  = 4'(GAP - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BLK_LEN - 1);

    seq_state_t        state_r;
    logic [15:0]       init_cnt_r;
    logic [3:0]        gap_cnt_r;
    logic [BEAT_W-1:0] beat_r;
    logic [15:0]       blks_r;
    logic              burst_r;
    logic              tp_r;
    logic              rd_d1_r;
    logic              tp_sel_s;

`ifdef DECODE_SEQ_TESTPAT_EN
    logic       tp_d1_r;
    logic [7:0] ramp_s;

    assign tp_sel_s = test_mode;

    decode_seq_tpg u_tpg (
        .clk   (clk),
        .rst_n (rst_n),
        .beat  (beat_r),
        .ramp  (ramp_s)
    );
`else
    logic unused_s;

    assign tp_sel_s = 1'b0;
    assign unused_s = test_mode ^ tp_r;
`endif

    // Sequencer FSM; every output it drives is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_INIT;
            init_cnt_r <= 16'd0;
            gap_cnt_r  <= 4'd0;
            beat_r     <= '0;
            blks_r     <= 16'd1;
            blk_cnt    <= 16'd0;
            burst_r    <= 1'b0;
            tp_r       <= 1'b0;
            src_rd     <= 1'b0;
            busy       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    if (init_cnt_r == INIT_LAST) begin
                        init_cnt_r <= 16'd0;
                        busy       <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        init_cnt_r <= init_cnt_r + 16'd1;
                    end
                end
                ST_IDLE: begin
                    if (start) begin
                        blks_r  <= norm_blks(frame_blks);
                        blk_cnt <= 16'd0;
                        busy    <= 1'b1;
                        state_r <= ST_WAIT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // Source choice is frozen for the whole burst.
                    if ((src_level >= BLK_LEVEL) || tp_sel_s) begin
                        beat_r  <= '0;
                        burst_r <= 1'b1;
                        tp_r    <= tp_sel_s;
                        src_rd  <= ~tp_sel_s;
                        state_r <= ST_BURST;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_BURST: begin
                    beat_r <= beat_r + {{(BEAT_W-1){1'b0}}, 1'b1};
                    if (beat_r == BEAT_LAST) begin
                        burst_r <= 1'b0;
                        src_rd  <= 1'b0;
                        blk_cnt <= blk_cnt + 16'd1;
                        if ((blk_cnt + 16'd1) == blks_r) begin
                            frame_done <= 1'b1;
                            state_r    <= ST_DONE;
                        end else begin
                            gap_cnt_r <= 4'd0;
                            state_r   <= ST_GAP;
                        end
                    end else begin
                        state_r <= ST_BURST;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r <= ST_WAIT;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    burst_r <= 1'b0;
                    src_rd  <= 1'b0;
                    busy    <= 1'b1;
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

    // Two-stage decoder pipeline: de follows the burst by 2, data is the read data registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_d1_r  <= 1'b0;
            dec_de   <= 1'b0;
            dec_data <= 8'd0;
`ifdef DECODE_SEQ_TESTPAT_EN
            tp_d1_r  <= 1'b0;
`endif
        end else begin
            rd_d1_r <= burst_r;
            dec_de  <= rd_d1_r;
`ifdef DECODE_SEQ_TESTPAT_EN
            tp_d1_r  <= burst_r & tp_r;
            dec_data <= tp_d1_r ? ramp_s : src_data;
`else
            dec_data <= src_data;
`endif
        end
    end

endmodule

// File: tb/tb_decode_burst_seq.sv
// Scoreboard bench for decode_burst_seq: FIFO model pushes expected bytes, monitor checks the decoder side.
module tb_decode_burst_seq;

    localparam int START_DLY = 400;
    localparam int GAP       = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] frame_blks = 16'd0;
    logic        test_mode = 1'b0;
    logic [4:0]  src_level = 5'd0;
    logic [7:0]  src_data;
    logic        src_rd;
    logic [7:0]  dec_data;
    logic        dec_de;
    logic        busy;
    logic [15:0] blk_cnt;
    logic        frame_done;

    decode_burst_seq #(.START_DLY(START_DLY), .GAP(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .frame_blks (frame_blks),
        .test_mode  (test_mode),
        .src_level  (src_level),
        .src_data   (src_data),
        .src_rd     (src_rd),
        .dec_data   (dec_data),
        .dec_de     (dec_de),
        .busy       (busy),
        .blk_cnt    (blk_cnt),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [4:0] lvl_edge = 5'd0;
    logic [7:0] exp_q[$];

    // Monitor state
    int run = 0, gap = 0, bursts = 0, fd_count = 0, last_rd_cyc = 0, fd_cyc = 0;
    bit prev_de = 0, prev_rd = 0, fd_pending = 0, had_burst = 0;
    bit fifo_frame = 1, steady = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        lvl_edge <= src_level;
    end

    // FIFO model: data appears the cycle after a pop, and the expected byte is queued.
    initial begin
        bit rd_prev;
        rd_prev  = 0;
        src_data = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_prev = 0;
            end else begin
                if (rd_prev) begin
                    src_data = 8'($urandom);
                    exp_q.push_back(src_data);
                end
                rd_prev = src_rd;
            end
        end
    end

    // Monitor: pops the scoreboard on every dec_de beat and checks burst shape and timing.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0; gap = 0; prev_de = 0; prev_rd = 0; fd_pending = 0; had_burst = 0;
                exp_q.delete();
            end else begin
                if (src_rd) last_rd_cyc = cyc;
                if (src_rd && !prev_rd) chk("lvl_gate", int'(lvl_edge >= 5'd16), 1);
                prev_rd = src_rd;
                if (frame_done) begin
                    fd_count++;
                    if (fifo_frame) chk("fd_after_rd", cyc - last_rd_cyc, 1);
                    fd_cyc = cyc;
                    fd_pending = 1;
                end
                if (dec_de) begin
                    if (!prev_de && had_burst) begin
                        if (steady) chk("gap_exact", gap, GAP + 1);
                        else        chk("gap_min", int'(gap >= GAP + 1), 1);
                    end
                    run++;
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dec_data", int'(dec_data), int'(e));
                    end
                    gap = 0;
                end else begin
                    if (prev_de) begin
                        chk("burst_len", run, 16);
                        bursts++;
                        run = 0;
                        if (fd_pending) begin
                            chk("fd_lead", (cyc - 1) - fd_cyc, 1);
                            fd_pending = 0;
                            had_burst = 0;
                        end else begin
                            had_burst = 1;
                        end
                    end
                    gap++;
                end
                prev_de = dec_de;
            end
        end
    end

    task automatic begin_frame(input logic [15:0] n, output int fd0, output int b0);
        fd0 = fd_count;
        b0  = bursts;
        frame_blks = n;
        start = 1'b1;
    endtask

    // Waits for frame completion, then checks frame-level totals.
    task automatic finish_frame(input int n_eff, input int fd0, input int b0, input bit rand_lvl,
                                input bit start_mid, input int exp_rd);
        bit done, pulsed;
        int rd_cnt;
        done = 0; pulsed = 0; rd_cnt = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (rand_lvl)
                src_level = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(16, 31));
            if (start_mid && !pulsed && dec_de) begin
                start = 1'b1;
                frame_blks = 16'd1;
                pulsed = 1;
            end
            rd_cnt += int'(src_rd);
            if (frame_done) done = 1;
        end
        chk("frame_end_seen", int'(done), 1);
        repeat (4) @(negedge clk);
        chk("frame_done_cnt", fd_count - fd0, 1);
        chk("burst_cnt", bursts - b0, n_eff);
        chk("blk_cnt", int'(blk_cnt), n_eff);
        chk("idle_after", int'(busy), 0);
        chk("sb_drain", exp_q.size(), 0);
        if (exp_rd >= 0) chk("rd_beats", rd_cnt, exp_rd);
    endtask

    initial begin
        int fd0, b0, cnt, n, n_eff;
        bit found;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_src_rd", int'(src_rd), 0);
        chk("rst_dec_de", int'(dec_de), 0);
        chk("rst_dec_data", int'(dec_data), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_blk_cnt", int'(blk_cnt), 0);
        chk("rst_frame_done", int'(frame_done), 0);

        // Start at cycle START_DLY-1 is dropped, at START_DLY accepted
        rst_n = 1'b1;
        repeat (START_DLY - 1) @(negedge clk);
        src_level = 5'd15;
        fifo_frame = 1; steady = 0;
        begin_frame(16'd2, fd0, b0);
        @(negedge clk);
        chk("start_early_ignored", int'(busy), 0);
        @(negedge clk);
        chk("start_accepted", int'(busy), 1);
        start = 1'b0;

        // Level throttling at 15, burst one cycle after reaching 16
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            cnt += int'(src_rd);
        end
        chk("thr_no_rd", cnt, 0);
        src_level = 5'd16;
        @(negedge clk);
        chk("thr_rd_start", int'(src_rd), 1);
        src_level = 5'd20;
        steady = 1;
        finish_frame(2, fd0, b0, 0, 0, -1);

        // Start while busy is dropped
        begin_frame(16'd3, fd0, b0);
        finish_frame(3, fd0, b0, 0, 1, 48);
        repeat (10) @(negedge clk);
        chk("no_queued_start", int'(busy), 0);
        chk("blk_cnt_hold", int'(blk_cnt), 3);

`ifdef DECODE_SEQ_TESTPAT_EN
        // Internal ramp source
        test_mode = 1'b1; src_level = 5'd0; fifo_frame = 0;
        for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
        begin_frame(16'd1, fd0, b0);
        finish_frame(1, fd0, b0, 0, 0, 0);
        test_mode = 1'b0; fifo_frame = 1;
`else
        // test_mode has no effect: still gated by FIFO level
        test_mode = 1'b1; src_level = 5'd0;
        begin_frame(16'd1, fd0, b0);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            start = 1'b0;
            cnt += int'(src_rd);
        end
        chk("tm_no_rd", cnt, 0);
        chk("tm_waiting", int'(busy), 1);
        src_level = 5'd20;
        finish_frame(1, fd0, b0, 0, 0, -1);
        test_mode = 1'b0;
`endif

        // Randomized frames with a fluctuating FIFO level
        steady = 0;
        for (int f = 0; f < 6; f++) begin
            n = (f == 0) ? 0 : $urandom_range(0, 4);
            n_eff = (n == 0) ? 1 : n;
            begin_frame(16'(n), fd0, b0);
            finish_frame(n_eff, fd0, b0, 1, 0, 16 * n_eff);
        end

        // Reset on beat 7 of a burst
        src_level = 5'd20; steady = 1;
        begin_frame(16'd2, fd0, b0);
        cnt = 0; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            start = 1'b0;
            cnt += int'(src_rd);
            if (cnt == 8) found = 1;
        end
        chk("rst_beat7_reached", int'(found), 1);
        chk("pre_rst_de", int'(dec_de), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_src_rd", int'(src_rd), 0);
        chk("mid_rst_dec_de", int'(dec_de), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_busy", int'(busy), 1);
        chk("post_rst_blk_cnt", int'(blk_cnt), 0);
        repeat (START_DLY - 1) @(negedge clk);
        chk("post_rst_full_dly", int'(busy), 1);
        @(negedge clk);
        chk("post_rst_idle", int'(busy), 0);

        // Recovery frame
        begin_frame(16'd1, fd0, b0);
        finish_frame(1, fd0, b0, 0, 0, 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule
